// File: rtl/desample_pkg.sv
// rtl/desample_pkg.sv - shared constants and helpers for the desample stream restorer
package desample_pkg;

  localparam int OVF_DROP_NEW = 0;
  localparam int OVF_DROP_OLD = 1;
  localparam int OVF_CNT_W    = 16;

  function automatic int clog2(input int n);
    int r;
    r = 0;
    for (int i = 0; i < 31; i++) begin
      if ((1 << i) < n) r = i + 1;
    end
    return r;
  endfunction

endpackage

// File: rtl/desample_fifo.sv
// rtl/desample_fifo.sv - circular buffer with full/empty and a forced read advance for drop-oldest
module desample_fifo
  import desample_pkg::*;
#(
  parameter int DEPTH = 4,
  parameter int W     = 8
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         wr_en,
  input  logic [W-1:0] wr_data,
  input  logic         rd_en,
  input  logic         force_adv,
  output logic [W-1:0] rd_data,
  output logic         full,
  output logic         empty
);

  localparam int AW = clog2(DEPTH);

  logic [AW:0]  wptr;
  logic [AW:0]  rptr;
  logic [W-1:0] mem [DEPTH];

  // One extra pointer bit distinguishes a full buffer from an empty one.
  assign full    = (wptr[AW] != rptr[AW]) && (wptr[AW-1:0] == rptr[AW-1:0]);
  assign empty   = (wptr == rptr);
  assign rd_data = mem[rptr[AW-1:0]];

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      wptr <= '0;
      rptr <= '0;
    end else begin
      if (wr_en) wptr <= wptr + 1'b1;
      if (rd_en || force_adv) rptr <= rptr + 1'b1;
    end
  end

  // Storage needs no reset: entries are only visible between the pointers.
  always_ff @(posedge clk) begin
    if (wr_en) mem[wptr[AW-1:0]] <= wr_data;
  end

endmodule

// File: rtl/desample.sv
// rtl/desample.sv - turns a valid-only sample source into a backpressured stream; DESAMPLE_OVF_CNT_EN adds ovf_cnt
module desample
  import desample_pkg::*;
#(
  parameter int DEPTH        = 4,
  parameter int W            = 8,
  parameter int CHANGES_ONLY = 0,
  parameter int DROP_OLDEST  = OVF_DROP_NEW
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic [W-1:0]         din_data,
  input  logic                 din_valid,
  output logic                 din_ready,
  output logic [W-1:0]         dout_data,
  output logic                 dout_valid,
  input  logic                 dout_ready,
  output logic                 ovf
`ifdef DESAMPLE_OVF_CNT_EN
  ,
  output logic [OVF_CNT_W-1:0] ovf_cnt
`endif
);

  localparam bit CHG_MODE  = (CHANGES_ONLY != 0);
  localparam bit DROP_MODE = (DROP_OLDEST == OVF_DROP_OLD);

  logic [W-1:0] last;
  logic         last_valid;
  logic         capture;
  logic         pop;
  logic         full;
  logic         empty;
  logic         lost;
  logic         wr_en;
  logic         force_adv;

  assign din_ready  = 1'b1;
  assign dout_valid = !empty;
  assign pop        = dout_valid && dout_ready;

  assign capture   = din_valid && (!CHG_MODE || !last_valid || (din_data != last));
  // A pop in the same cycle frees the slot, so a full FIFO only loses data without one.
  assign lost      = capture && full && !pop;
  assign wr_en     = capture && (!full || pop || DROP_MODE);
  assign force_adv = lost && DROP_MODE;

  desample_fifo #(
    .DEPTH (DEPTH),
    .W     (W)
  ) u_fifo (
    .clk       (clk),
    .rst       (rst),
    .wr_en     (wr_en),
    .wr_data   (din_data),
    .rd_en     (pop),
    .force_adv (force_adv),
    .rd_data   (dout_data),
    .full      (full),
    .empty     (empty)
  );

  // Change detection follows captured samples, including ones lost to overflow.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      last       <= '0;
      last_valid <= 1'b0;
    end else if (capture) begin
      last       <= din_data;
      last_valid <= 1'b1;
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      ovf <= 1'b0;
    end else if (lost) begin
      ovf <= 1'b1;
    end
  end

`ifdef DESAMPLE_OVF_CNT_EN
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      ovf_cnt <= '0;
    end else if (lost && (ovf_cnt != {OVF_CNT_W{1'b1}})) begin
      ovf_cnt <= ovf_cnt + 1'b1;
    end
  end
`endif

endmodule

// File: doc/desample.md
# desample

Stream-restoring counterpart of the sampling stage. It accepts a valid-only data source that never honours backpressure (`din.ready` is tied high) and turns it into a lossless-where-possible `dti` handshake stream on `dout`. Samples are buffered in a small FIFO so that downstream stalls do not lose data. It can optionally emit only on value changes. It sits between free-running producers (sensors, sampled state, `sample` outputs) and normal backpressured pipeline stages.

## Interface
Parameters:
- `DEPTH`, 4: FIFO entries; power of two, ≥2.
- `CHANGES_ONLY`, 0: 1 = capture only when `din.data` differs from the last captured value.
- `DROP_OLDEST`, 0: overflow policy; 0 = discard incoming sample, 1 = overwrite oldest entry.

Ports:
- `clk`  in  1  clock, all logic on rising edge.
- `rst`  in  1  asynchronous, active-low reset (asserted at 0).
- `din`  dti.consumer  W = `$size(din.data)`  sampled input; `din.ready` is constant 1.
- `dout`  dti.producer  W  handshaked output stream.
- `ovf`  out  1  sticky overflow flag.
- `ovf_cnt`  out  16  saturating count of lost samples; present only with `DESAMPLE_OVF_CNT_EN`.

## Operation
- Capture condition: `din.valid && (!CHANGES_ONLY || !last_valid || din.data != last)`.
- On capture, `last <= din.data` and `last_valid <= 1`. `last` tracks captured values, not emitted ones, and updates even when the sample is dropped on overflow.
- FIFO state: read pointer and write pointer, each log2(DEPTH)+1 bits. Full when the MSBs differ and the low bits are equal. Empty when the pointers are equal.
- Pop happens on `dout.valid && dout.ready`. `dout.data` is the entry at the read pointer.
- Push/pop cases:
  - Not full: push writes at the write pointer.
  - Full with a pop in the same cycle: push is accepted and `ovf` does not set.
  - Full with no pop, `DROP_OLDEST=0`: the sample is discarded, `ovf <= 1`.
  - Full with no pop, `DROP_OLDEST=1`: the sample is written at the write pointer, both pointers advance, `ovf <= 1`.
- `ovf` clears only on reset.
- `dout.valid` equals `!empty`. Once asserted, it and `dout.data` stay stable until the handshake, except under `DROP_OLDEST=1` overflow, where the head advances.
- Reset values: pointers 0, `dout.valid` 0, `ovf` 0, `last_valid` 0, `ovf_cnt` 0. Reset mid-stream flushes all entries immediately (asynchronous); no partial transfer completes.

## Timing
- Latency from `din.valid` to `dout.valid` is 1 cycle (registered FIFO, no bypass).
- Throughput is one sample per cycle, in and out, with a non-stalling consumer.
- With `dout.ready` held low, exactly DEPTH samples are retained. Sample DEPTH+1 sets `ovf` on the cycle after it is presented.
- `ovf_cnt` increments in the same cycle `ovf` would set, and saturates at 0xFFFF.

## Configuration
- `DESAMPLE_OVF_CNT_EN` defined: the `ovf_cnt` port and its 16-bit saturating counter are compiled in.
- Not defined: the port and the counter are absent; `ovf` alone reports loss.

## Structure
- `desample_pkg` holds:
  - the overflow-policy constants (`OVF_DROP_NEW`, `OVF_DROP_OLD`);
  - the `OVF_CNT_W = 16` constant;
  - the pointer-width function `clog2`.
- Sub-module `desample_fifo`: circular buffer with full/empty, forced-advance input for drop-oldest, one write and one read port. The top level holds the capture/change-detect logic, `ovf` and the counter.

## Test plan
- Back-to-back: `din` = 1,2,3,4,5 on consecutive cycles, `dout.ready`=1 → `dout` = 1..5, each 1 cycle late, `ovf`=0.
- Stall overflow: `DEPTH=4`, `DROP_OLDEST=0`, ready=0, push 10..15 → FIFO holds 10..13, `ovf`=1, `ovf_cnt`=2. Then ready=1 drains 10,11,12,13.
- Drop-oldest: same stimulus with `DROP_OLDEST=1` → drains 12,13,14,15, `ovf`=1.
- Full with simultaneous pop: fill 4 entries, then assert ready and push 20 in the same cycle → no overflow; output order ends …,20.
- Change-only: `CHANGES_ONLY=1`, inputs 7,7,7,8,8,7 → `dout` = 7,8,7. After reset, input 7 is emitted again.
- Async reset: assert `rst`=0 mid-burst with 3 entries queued → `dout.valid`, `ovf` and `ovf_cnt` go 0 before the next clock edge. After release, the next sample appears with 1-cycle latency.
